// File: rtl/wb_ram_responder_pkg.sv
// wb_ram_responder_pkg: shared response type, LFSR seed and address range check for the Wishbone RAM responder.
package wb_ram_responder_pkg;
    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } resp_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic in_range(input logic [63:0] adr, input logic [63:0] depth);
        return adr < depth;
    endfunction
endpackage

// File: rtl/wb_resp_pipe.sv
// wb_resp_pipe: LATENCY-deep response delay line; flush drops in-flight responses, data holds the last valid word.
module wb_resp_pipe
    import wb_ram_responder_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_flush,
    input  resp_t i_resp,
    output resp_t o_resp
);
    resp_t r_stage [LATENCY];
    resp_t w_in    [LATENCY];

    always_comb begin
        w_in[0] = i_resp;
        for (int i = 1; i < LATENCY; i++) w_in[i] = r_stage[i - 1];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LATENCY; i++) begin
            if (rst) begin
                r_stage[i] <= '0;
            end else begin
                r_stage[i].valid <= w_in[i].valid & ~i_flush;
                r_stage[i].err   <= w_in[i].err;
                if (w_in[i].valid & ~i_flush) r_stage[i].data <= w_in[i].data;
            end
        end
    end

    assign o_resp = r_stage[LATENCY - 1];
endmodule

// File: rtl/wb_ram_responder.sv
// wb_ram_responder: pipelined Wishbone B4 RAM responder, fixed latency, err on out-of-range addresses.
// Define WB_RAM_RESPONDER_STALL_INJECT_EN to add LFSR-driven stall injection.
module wb_ram_responder
    import wb_ram_responder_pkg::*;
#(
    parameter int    ADDR_W      = 28,
    parameter int    DEPTH_WORDS = 1024,
    parameter int    LATENCY     = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    input  logic              i_wb_we,
    input  logic [ADDR_W-1:0] i_wb_adr,
    input  logic [3:0]        i_wb_sel,
    input  logic [31:0]       i_wb_dat,
    output logic              o_wb_ack,
    output logic              o_wb_err,
    output logic              o_wb_stall,
    output logic [31:0]       o_wb_dat
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      r_ram [DEPTH_WORDS];
    logic [31:0]      r_rd;
    logic             r_vld;
    logic             r_err;
    logic             r_rd_en;
    logic             w_acc;
    logic             w_in;
    logic [IDX_W-1:0] w_idx;
    resp_t            w_req;
    resp_t            w_out;

    initial begin
        for (int i = 0; i < DEPTH_WORDS; i++) r_ram[i] = '0;
    end

    assign w_acc = i_wb_cyc & i_wb_stb & ~o_wb_stall;
    assign w_in  = in_range(64'(i_wb_adr), 64'(DEPTH_WORDS));
    assign w_idx = i_wb_adr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (w_acc & w_in & i_wb_we)
            for (int b = 0; b < 4; b++)
                if (i_wb_sel[b]) r_ram[w_idx][8*b +: 8] <= i_wb_dat[8*b +: 8];
        r_rd <= r_ram[w_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld   <= 1'b0;
            r_err   <= 1'b0;
            r_rd_en <= 1'b0;
        end else begin
            r_vld   <= w_acc;
            r_err   <= w_acc & ~w_in;
            r_rd_en <= w_acc & w_in & ~i_wb_we;
        end
    end

    // Only in-range reads carry RAM data; writes and errors return zero.
    assign w_req = {r_vld, r_err, r_rd_en ? r_rd : 32'd0};

    wb_resp_pipe #(.LATENCY(LATENCY)) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_flush(rst | ~i_wb_cyc),
        .i_resp (w_req),
        .o_resp (w_out)
    );

    assign o_wb_ack = w_out.valid & ~w_out.err;
    assign o_wb_err = w_out.valid & w_out.err;
    assign o_wb_dat = w_out.data;

`ifdef WB_RAM_RESPONDER_STALL_INJECT_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        r_lfsr <= rst ? LFSR_SEED : {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

    assign o_wb_stall = r_lfsr[0] & r_lfsr[1];
`else
    assign o_wb_stall = 1'b0;
`endif
endmodule

// File: tb/tb_wb_ram_responder.sv
// tb_wb_ram_responder: drives four responders (LATENCY 1..4) with shared stimulus, checked by a queue-based model.
module tb_wb_ram_responder;
    localparam int DEPTH = 1024;

    typedef struct {int due; bit err; bit rd; logic [31:0] d;} exp_t;
    typedef struct {int at; bit err; logic [31:0] d;} obs_t;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        cyc  = 1'b0;
    logic        stb  = 1'b0;
    logic        we   = 1'b0;
    logic [27:0] adr  = '0;
    logic [3:0]  sel  = '0;
    logic [31:0] wdat = '0;
    logic        ack   [4];
    logic        err   [4];
    logic        stall [4];
    logic [31:0] dat   [4];

    exp_t        pend [4][$];
    obs_t        seen [4][$];
    logic [31:0] mem [DEPTH];
    logic [15:0] m_lfsr = 16'hACE1;
    int          edge_n = 0;
    int          total  = 0;
    int          bad    = 0;
    bit          armed  = 0;
    bit          st0    = 0;
    bit          st1    = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        wb_ram_responder #(.LATENCY(g + 1)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .i_wb_cyc  (cyc),
            .i_wb_stb  (stb),
            .i_wb_we   (we),
            .i_wb_adr  (adr),
            .i_wb_sel  (sel),
            .i_wb_dat  (wdat),
            .o_wb_ack  (ack[g]),
            .o_wb_err  (err[g]),
            .o_wb_stall(stall[g]),
            .o_wb_dat  (dat[g])
        );
    end

    function automatic bit exp_stall();
`ifdef WB_RAM_RESPONDER_STALL_INJECT_EN
        return m_lfsr[0] & m_lfsr[1];
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(string nm, int g, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s lat=%0d edge=%0d got=%h want=%h", nm, g + 1, edge_n, act, want);
        end
    endtask

    // Reference model: each accepted request is due exactly LATENCY edges later; abort/reset drops everything pending.
    always @(posedge clk) begin
        bit          st;
        bit          inr;
        logic [31:0] r;
        edge_n++;
        st = exp_stall();
        m_lfsr = rst ? 16'hACE1 : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        if (rst || !cyc) begin
            for (int g = 0; g < 4; g++) pend[g].delete();
        end else if (stb && !st) begin
            inr = adr < 28'(DEPTH);
            r = (inr && !we) ? mem[adr[9:0]] : 32'd0;
            if (inr && we)
                for (int b = 0; b < 4; b++)
                    if (sel[b]) mem[adr[9:0]][8*b +: 8] = wdat[8*b +: 8];
            for (int g = 0; g < 4; g++) pend[g].push_back('{edge_n + g + 1, !inr, inr && !we, r});
        end
    end

    always @(negedge clk) begin
        exp_t e;
        bit   ev;
        if (armed) begin
            for (int g = 0; g < 4; g++) begin
                ev = pend[g].size() > 0 && pend[g][0].due == edge_n;
                if (ev) e = pend[g].pop_front();
                chk("ack", g, 32'(ack[g]), 32'(ev && !e.err));
                chk("err", g, 32'(err[g]), 32'(ev && e.err));
                chk("stall", g, 32'(stall[g]), 32'(exp_stall()));
                if (ev && (e.err || e.rd)) chk("dat", g, dat[g], e.d);
                if (ack[g] || err[g]) seen[g].push_back('{edge_n, err[g], dat[g]});
                if (stall[g]) st1 = 1; else st0 = 1;
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_seen();
        for (int g = 0; g < 4; g++) seen[g].delete();
    endtask

    task automatic req(bit w, logic [27:0] a, logic [3:0] s, logic [31:0] d, output int at);
        int n;
        bit ok;
        n  = 0;
        ok = 0;
        cyc = 1; stb = 1; we = w; adr = a; sel = s; wdat = d;
        while (!ok && n < 40) begin
            @(negedge clk);
            ok = !stall[0];
            @(posedge clk);
            #1;
            n++;
        end
        at  = edge_n;
        stb = 0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL req_accept adr=%h got=stalled want=accepted", a);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=no_finish want=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a0;
        int a1;
        int drop;
        int acc [4];
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        tick(3);
        armed = 1;
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            chk("rst_ack", g, 32'(ack[g]), 0);
            chk("rst_err", g, 32'(err[g]), 0);
            chk("rst_stall", g, 32'(stall[g]), 0);
            chk("rst_dat", g, dat[g], 0);
        end
        @(posedge clk);
        #1;
        rst = 0;

        clear_seen();
        req(1, 28'd5, 4'hF, 32'hDEADBEEF, a0);
        req(0, 28'd5, 4'h0, 32'd0, a1);
        tick(6);
        for (int g = 0; g < 4; g++) begin
            chk("t1_count", g, seen[g].size(), 2);
            chk("t1_wr_at", g, seen[g][0].at, a0 + g + 1);
            chk("t1_rd_at", g, seen[g][1].at, a1 + g + 1);
            chk("t1_rd_dat", g, seen[g][1].d, 32'hDEADBEEF);
        end

        clear_seen();
        req(1, 28'd7, 4'hF, 32'h11223344, a0);
        req(1, 28'd7, 4'b0101, 32'hAABBCCDD, a0);
        req(0, 28'd7, 4'hF, 32'd0, a1);
        tick(6);
        for (int g = 0; g < 4; g++) begin
            chk("t2_count", g, seen[g].size(), 3);
            chk("t2_sel_dat", g, seen[g][2].d, 32'h11BB33DD);
        end

        for (int i = 0; i < 4; i++) req(1, 28'(i), 4'hF, 32'(i), a0);
        tick(6);
        clear_seen();
        for (int i = 0; i < 4; i++) req(0, 28'(i), 4'h0, 32'd0, acc[i]);
        tick(6);
        for (int g = 0; g < 4; g++) begin
            chk("t3_count", g, seen[g].size(), 4);
            for (int i = 0; i < 4; i++) begin
                chk("t3_dat", g, seen[g][i].d, 32'(i));
                chk("t3_at", g, seen[g][i].at, acc[i] + g + 1);
            end
        end

        clear_seen();
        req(0, 28'd1024, 4'hF, 32'd0, a0);
        req(0, 28'd1023, 4'hF, 32'd0, a1);
        req(0, 28'h4000005, 4'hF, 32'd0, a0);
        req(1, 28'hFFFFFFF, 4'hF, 32'h12345678, a0);
        tick(6);
        for (int g = 0; g < 4; g++) begin
            chk("t4_count", g, seen[g].size(), 4);
            chk("t4_oob_err", g, 32'(seen[g][0].err), 1);
            chk("t4_oob_dat", g, seen[g][0].d, 0);
            chk("t4_top_err", g, 32'(seen[g][1].err), 0);
            chk("t4_alias_err", g, 32'(seen[g][2].err), 1);
            chk("t4_max_err", g, 32'(seen[g][3].err), 1);
        end

        clear_seen();
        req(0, 28'd5, 4'hF, 32'd0, a0);
        req(0, 28'd7, 4'hF, 32'd0, a1);
        cyc = 0;
        stb = 1;
        adr = 28'd5;
        drop = a1 + 1;
        tick(6);
        stb = 0;
        for (int g = 0; g < 4; g++)
            chk("t5_abort_count", g, seen[g].size(), 32'(a0 + g + 1 < drop) + 32'(a1 + g + 1 < drop));
        clear_seen();
        req(0, 28'd7, 4'hF, 32'd0, a1);
        tick(6);
        for (int g = 0; g < 4; g++) begin
            chk("t5_resume_count", g, seen[g].size(), 1);
            chk("t5_resume_dat", g, seen[g][0].d, 32'h11BB33DD);
        end

        for (int i = 0; i < 100; i++) begin
            logic [27:0] a;
            a = ($urandom_range(0, 7) == 0) ? 28'($urandom_range(1020, 1030)) : 28'($urandom_range(0, 15));
            req($urandom_range(0, 1) == 1, a, 4'($urandom_range(0, 15)), $urandom, a0);
        end
        tick(8);
`ifdef WB_RAM_RESPONDER_STALL_INJECT_EN
        chk("stall_seen_low", 0, 32'(st0), 1);
        chk("stall_seen_high", 0, 32'(st1), 1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
